// File: rtl/tcm_arb.sv
// Three-master arbiter (mp read/write, lpc read, sdhci write) onto one TCM request port.
// Fixed priority a > b > c by default; define TCM_ARB_RR_EN for round-robin arbitration.
module tcm_arb #(
    parameter int AW = 16,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst,
    // port a: mp, read and write
    input  logic          a_read_request,
    input  logic          a_write_request,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_write_data,
    output logic          a_request_finish,
    output logic [DW-1:0] a_read_data,
    // port b: lpc, read only
    input  logic          b_read_request,
    input  logic [AW-1:0] b_addr,
    output logic          b_request_finish,
    output logic [DW-1:0] b_read_data,
    // port c: sdhci, write only
    input  logic          c_write_request,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_write_data,
    output logic          c_request_finish,
    // TCM master port
    output logic          m_read_request,
    output logic          m_write_request,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_write_data,
    input  logic          m_request_finish,
    input  logic [DW-1:0] m_read_data,
    // status
    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_A    = 2'd1;
    localparam logic [1:0] GNT_B    = 2'd2;
    localparam logic [1:0] GNT_C    = 2'd3;

    state_t     state;
    state_t     state_next;
    logic [1:0] grant_q;
    logic [1:0] winner;
    logic [2:0] req_vec;
    logic       txn_done;

    assign req_vec  = {c_write_request, b_read_request, a_read_request | a_write_request};
    assign txn_done = (state == BUSY) && m_request_finish;

`ifdef TCM_ARB_RR_EN
    // rr_ptr holds the port index (0 a, 1 b, 2 c) where the next search begins.
    logic [1:0] rr_ptr;

    always_comb begin
        winner = GNT_NONE;
        // Walk from the farthest offset down so the nearest pending port wins.
        for (int k = 2; k >= 0; k--) begin
            if (req_vec[(int'(rr_ptr) + k) % 3]) begin
                winner = 2'(((int'(rr_ptr) + k) % 3) + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (txn_done) begin
            rr_ptr <= (grant_q == GNT_C) ? 2'd0 : grant_q;
        end
    end
`else
    always_comb begin
        // NOTE: every path assigns winner first, so no latch is inferred.
        winner = GNT_NONE;
        if (req_vec[0]) begin
            winner = GNT_A;
        end else if (req_vec[1]) begin
            winner = GNT_B;
        end else if (req_vec[2]) begin
            winner = GNT_C;
        end
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (winner != GNT_NONE) state_next = BUSY;
            BUSY:    if (m_request_finish) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The granted request is captured once; a master dropping its request mid-transaction
    // therefore cannot cancel what the TCM already sees.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q         <= GNT_NONE;
            m_read_request  <= 1'b0;
            m_write_request <= 1'b0;
            m_addr          <= '0;
            m_write_data    <= '0;
        end else if (state == IDLE && winner != GNT_NONE) begin
            grant_q <= winner;
            case (winner)
                GNT_A: begin
                    m_read_request  <= ~a_write_request;
                    m_write_request <= a_write_request;
                    m_addr          <= a_addr;
                    m_write_data    <= a_write_request ? a_write_data : '0;
                end
                GNT_B: begin
                    m_read_request  <= 1'b1;
                    m_write_request <= 1'b0;
                    m_addr          <= b_addr;
                    m_write_data    <= '0;
                end
                default: begin
                    m_read_request  <= 1'b0;
                    m_write_request <= 1'b1;
                    m_addr          <= c_addr;
                    m_write_data    <= c_write_data;
                end
            endcase
        end else if (txn_done) begin
            grant_q         <= GNT_NONE;
            m_read_request  <= 1'b0;
            m_write_request <= 1'b0;
            m_addr          <= '0;
            m_write_data    <= '0;
        end
    end

    assign grant = grant_q;
    assign busy  = (state != IDLE);

    assign a_request_finish = txn_done && (grant_q == GNT_A);
    assign b_request_finish = txn_done && (grant_q == GNT_B);
    assign c_request_finish = txn_done && (grant_q == GNT_C);

    assign a_read_data = (grant_q == GNT_A) ? m_read_data : '0;
    assign b_read_data = (grant_q == GNT_B) ? m_read_data : '0;

endmodule
